// File: rtl/axis_downsizer_if.sv
// AXI Stream handshake bundle (tvalid/tready/tdata) shared by the downsizer and its neighbours.
// Modport m drives the stream, modport s consumes it.
interface axis_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport m (output tvalid, output tdata, input tready);
  modport s (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_downsizer.sv
// AXI Stream width downsizer: one wide word in, RATIO narrow beats out, least-significant slice first.
// Define AXIS_DOWNSIZER_PREFETCH_EN to reload on the final beat for full output throughput.
module axis_downsizer #(
  parameter int RATIO = 2
) (
  input  logic clk,
  input  logic rst,
  axis_if.s    axis_sif,
  axis_if.m    axis_mif,
  input  logic invalidate
);

  localparam int IN_W  = $bits(axis_sif.tdata);
  localparam int OUT_W = $bits(axis_mif.tdata);
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  if (OUT_W <= 0) begin : g_bad_out_w
    $fatal(1, "axis_downsizer: OUT_W must be > 0");
  end
  if (RATIO < 1) begin : g_bad_ratio
    $fatal(1, "axis_downsizer: RATIO must be >= 1");
  end
  if (IN_W != RATIO * OUT_W) begin : g_bad_in_w
    $fatal(1, "axis_downsizer: IN_W must equal RATIO*OUT_W");
  end

  logic             buf_valid;
  logic [IN_W-1:0]  buf_data;
  logic [IDX_W-1:0] idx;

  logic last;
  logic m_hs;
  logic s_hs;
  logic prefetch;

  assign last = buf_valid && (idx == IDX_LAST);
  assign m_hs = buf_valid && axis_mif.tready;
  assign s_hs = axis_sif.tvalid && axis_sif.tready;

`ifdef AXIS_DOWNSIZER_PREFETCH_EN
  // Accept the next word while the final beat leaves; adds a tready-to-tready path.
  assign prefetch = last && axis_mif.tready;
`else
  assign prefetch = 1'b0;
`endif

  assign axis_sif.tready = !rst && !invalidate && (!buf_valid || prefetch);

  assign axis_mif.tvalid = buf_valid;
  assign axis_mif.tdata  = buf_data[int'(idx) * OUT_W +: OUT_W];

  // Holding stage: wide word plus the index of the slice currently presented
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      idx       <= '0;
      buf_data  <= '0;
    end else if (invalidate) begin
      buf_valid <= 1'b0;
      idx       <= '0;
    end else if (s_hs) begin
      buf_data  <= axis_sif.tdata;
      idx       <= '0;
      buf_valid <= 1'b1;
    end else if (m_hs) begin
      if (last) begin
        idx       <= '0;
        buf_valid <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Bench for axis_downsizer: directed table and corner sequences on a 32->8 instance,
// randomized queue-model checks on 32->8 and 16->16 instances.
module tb_axis_downsizer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic inv4;
  logic inv1;

  axis_if #(.TDATA_WIDTH(32)) s4 ();
  axis_if #(.TDATA_WIDTH(8))  m4 ();
  axis_if #(.TDATA_WIDTH(16)) s1 ();
  axis_if #(.TDATA_WIDTH(16)) m1 ();

  axis_downsizer #(.RATIO(4)) dut4 (
    .clk(clk), .rst(rst), .axis_sif(s4), .axis_mif(m4), .invalidate(inv4)
  );
  axis_downsizer #(.RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .axis_sif(s1), .axis_mif(m1), .invalidate(inv1)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct packed {
    logic [31:0] word;
    logic [7:0]  e0;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [7:0]  e3;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Offer a word on the wide side; returns one cycle after the handshake, sampled.
  task automatic send4(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    s4.tvalid = 1'b1;
    s4.tdata  = w;
    #1;
    while (!s4.tready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("send4_timeout", 32'd0, 32'd1);
    @(negedge clk);
    s4.tvalid = 1'b0;
    #1;
  endtask

  // Check the current narrow beat, then move to the next cycle's sample point.
  task automatic expect_beat(input string name, input logic [7:0] exp);
    check(name, {23'd0, m4.tvalid, m4.tdata}, {23'd0, 1'b1, exp});
    @(negedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [4];
    logic [31:0] b2b_w [2];
    logic [8:0]  b2b_exp [10];
    logic [8:0]  obs;
    logic [7:0]  q4 [$];
    logic [15:0] q1 [$];
    logic [7:0]  e8;
    logic [15:0] e16;
    logic [31:0] w32;
    logic        hs;
    int          wi;

    tbl[0] = '{word: 32'h44332211, e0: 8'h11, e1: 8'h22, e2: 8'h33, e3: 8'h44};
    tbl[1] = '{word: 32'hDDCCBBAA, e0: 8'hAA, e1: 8'hBB, e2: 8'hCC, e3: 8'hDD};
    tbl[2] = '{word: 32'h04030201, e0: 8'h01, e1: 8'h02, e2: 8'h03, e3: 8'h04};
    tbl[3] = '{word: 32'h88776655, e0: 8'h55, e1: 8'h66, e2: 8'h77, e3: 8'h88};

`ifdef AXIS_DOWNSIZER_PREFETCH_EN
    b2b_exp = '{9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD, 9'h101, 9'h102, 9'h103, 9'h104, 9'h000, 9'h000};
`else
    b2b_exp = '{9'h1AA, 9'h1BB, 9'h1CC, 9'h1DD, 9'h000, 9'h101, 9'h102, 9'h103, 9'h104, 9'h000};
`endif
    b2b_w[0] = 32'hDDCCBBAA;
    b2b_w[1] = 32'h04030201;

    rst = 1'b1; inv4 = 1'b0; inv1 = 1'b0;
    s4.tvalid = 1'b0; s4.tdata = '0; m4.tready = 1'b0;
    s1.tvalid = 1'b0; s1.tdata = '0; m1.tready = 1'b0;

    // Reset state and release
    repeat (3) @(negedge clk);
    s4.tvalid = 1'b1;
    m4.tready = 1'b1;
    #1;
    check("rst_mvalid4", {31'd0, m4.tvalid}, 32'd0);
    check("rst_sready4", {31'd0, s4.tready}, 32'd0);
    check("rst_mvalid1", {31'd0, m1.tvalid}, 32'd0);
    check("rst_sready1", {31'd0, s1.tready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    s4.tvalid = 1'b0;
    #1;
    check("rel_sready4", {31'd0, s4.tready}, 32'd1);
    check("rel_mvalid4", {31'd0, m4.tvalid}, 32'd0);

    // Table-driven single words, ready always high
    for (int i = 0; i < 4; i++) begin
      m4.tready = 1'b1;
      send4(tbl[i].word);
      expect_beat("tbl_b0", tbl[i].e0);
      expect_beat("tbl_b1", tbl[i].e1);
      expect_beat("tbl_b2", tbl[i].e2);
      expect_beat("tbl_b3", tbl[i].e3);
      check("tbl_idle", {31'd0, m4.tvalid}, 32'd0);
    end

    // Back-to-back words
    m4.tready = 1'b1;
    wi = 0;
    @(negedge clk);
    s4.tvalid = 1'b1;
    s4.tdata  = b2b_w[0];
    #1;
    hs = s4.tvalid && s4.tready;
    check("b2b_first_hs", {31'd0, hs}, 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (hs) wi++;
      if (wi < 2) begin
        s4.tvalid = 1'b1;
        s4.tdata  = b2b_w[wi];
      end else begin
        s4.tvalid = 1'b0;
      end
      #1;
      obs = {m4.tvalid, m4.tvalid ? m4.tdata : 8'h00};
      check($sformatf("b2b_c%0d", c), {23'd0, obs}, {23'd0, b2b_exp[c]});
      hs = s4.tvalid && s4.tready;
    end
    s4.tvalid = 1'b0;

    // Backpressure at idx=2
    m4.tready = 1'b1;
    send4(32'h44332211);
    expect_beat("bp_b0", 8'h11);
    expect_beat("bp_b1", 8'h22);
    m4.tready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp_hold", {23'd0, m4.tvalid, m4.tdata}, {23'd0, 1'b1, 8'h33});
      check("bp_sready", {31'd0, s4.tready}, 32'd0);
      @(negedge clk);
    end
    m4.tready = 1'b1;
    #1;
    expect_beat("bp_b2", 8'h33);
    expect_beat("bp_b3", 8'h44);
    check("bp_idle", {31'd0, m4.tvalid}, 32'd0);

    // Invalidate after the 0x22 beat
    send4(32'h44332211);
    expect_beat("inv_b0", 8'h11);
    expect_beat("inv_b1", 8'h22);
    inv4      = 1'b1;
    m4.tready = 1'b0;
    s4.tvalid = 1'b1;
    s4.tdata  = 32'h88776655;
    #1;
    check("inv_sready", {31'd0, s4.tready}, 32'd0);
    @(negedge clk);
    inv4 = 1'b0;
    #1;
    check("inv_mvalid", {31'd0, m4.tvalid}, 32'd0);
    check("inv_sready_after", {31'd0, s4.tready}, 32'd1);
    @(negedge clk);
    s4.tvalid = 1'b0;
    m4.tready = 1'b1;
    #1;
    expect_beat("inv_n0", 8'h55);
    expect_beat("inv_n1", 8'h66);
    expect_beat("inv_n2", 8'h77);
    expect_beat("inv_n3", 8'h88);
    check("inv_idle", {31'd0, m4.tvalid}, 32'd0);

    // Reset in the middle of a word
    send4(32'h44332211);
    expect_beat("rm_b0", 8'h11);
    rst = 1'b1;
    #1;
    check("rm_sready_in_rst", {31'd0, s4.tready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rm_mvalid", {31'd0, m4.tvalid}, 32'd0);
    check("rm_sready", {31'd0, s4.tready}, 32'd1);
    send4(32'h88776655);
    expect_beat("rm_n0", 8'h55);
    expect_beat("rm_n1", 8'h66);
    expect_beat("rm_n2", 8'h77);
    expect_beat("rm_n3", 8'h88);

    // Randomized RATIO=4 against a beat queue
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (c < 400) begin
        s4.tvalid = ($urandom_range(0, 1) == 1);
        s4.tdata  = $urandom;
        m4.tready = ($urandom_range(0, 3) != 0);
      end else begin
        s4.tvalid = 1'b0;
        m4.tready = 1'b1;
      end
      #1;
      check("r4_valid", {31'd0, m4.tvalid}, {31'd0, q4.size() != 0});
      if (m4.tvalid && m4.tready && q4.size() != 0) begin
        e8 = q4.pop_front();
        check("r4_beat", {24'd0, m4.tdata}, {24'd0, e8});
      end
      if (s4.tvalid && s4.tready) begin
        w32 = s4.tdata;
        for (int k = 0; k < 4; k++) q4.push_back(w32[k*8 +: 8]);
      end
    end
    check("r4_drain", q4.size(), 32'd0);

    // Randomized RATIO=1 against a word queue
    for (int c = 0; c < 1010; c++) begin
      @(negedge clk);
      if (c < 1000) begin
        s1.tvalid = ($urandom_range(0, 1) == 1);
        s1.tdata  = 16'($urandom);
        m1.tready = ($urandom_range(0, 1) == 1);
      end else begin
        s1.tvalid = 1'b0;
        m1.tready = 1'b1;
      end
      #1;
      check("r1_valid", {31'd0, m1.tvalid}, {31'd0, q1.size() != 0});
      check("r1_depth", {31'd0, q1.size() <= 1}, 32'd1);
      if (m1.tvalid && m1.tready && q1.size() != 0) begin
        e16 = q1.pop_front();
        check("r1_word", {16'd0, m1.tdata}, {16'd0, e16});
      end
      if (s1.tvalid && s1.tready) q1.push_back(s1.tdata);
    end
    check("r1_drain", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/axis_downsizer.md
Name: axis_downsizer

Overview:
AXI Stream width downsizer. Accepts one wide word on its subordinate side and emits it as RATIO narrow beats on its manager side, least-significant slice first. It is the consumer-side counterpart to the stream register slices in the core. It sits where a wide producer (fetch line, wide bus read) feeds a narrow pipeline stage (instruction or halfword decode). It honours backpressure on both sides and supports a single-cycle flush via invalidate.

Parameters:
RATIO, 2, number of narrow beats per wide word; must be >= 1.
(Widths are taken from the interfaces: IN_W = axis_sif.TDATA_WIDTH, OUT_W = axis_mif.TDATA_WIDTH.)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
axis_sif  axis_if.s  IN_W  wide input stream (tvalid, tready, tdata)
axis_mif  axis_if.m  OUT_W  narrow output stream (tvalid, tready, tdata)
invalidate  input  1  flush: discard the held word and any remaining beats

Behaviour:
- Elaboration checks (initial assert/$fatal): OUT_W > 0; RATIO >= 1; IN_W == RATIO*OUT_W.
- State: buf_valid (1b), buf_data (IN_W), idx (IDX_W = max(1, $clog2(RATIO)) bits).
- Outputs: axis_mif.tvalid = buf_valid; axis_mif.tdata = buf_data[idx*OUT_W +: OUT_W].
- last = buf_valid && (idx == RATIO-1); m_hs = buf_valid && axis_mif.tready; s_hs = axis_sif.tvalid && axis_sif.tready.
- axis_sif.tready = !rst && !invalidate && (!buf_valid || <prefetch term, see Optional Feature>).
- Reset: buf_valid=0, idx=0, buf_data=0; so axis_mif.tvalid=0 and axis_sif.tready=0 while rst is high. The cycle after rst deasserts, axis_sif.tready=1.
- Priority per cycle: rst > invalidate > normal operation.
- invalidate: buf_valid<=0, idx<=0; buf_data is held. axis_sif.tready is 0 in that cycle, so no input word is lost. A beat handshaken on axis_mif in the invalidate cycle counts as delivered. The remaining beats are dropped.
- s_hs: buf_data<=axis_sif.tdata, idx<=0, buf_valid<=1.
- m_hs && !last: idx<=idx+1.
- m_hs && last: idx<=0; buf_valid<=0 unless s_hs in the same cycle, in which case the s_hs load wins.
- Latency: first narrow beat is valid 1 cycle after s_hs. A word occupies exactly RATIO mif handshakes.
- Beats are never skipped or repeated. tdata is stable while tvalid && !tready (AXIS rule).
- RATIO=1: behaves as a single-entry forward register slice (idx is constant 0).
- Throughput: see Optional Feature.

Optional Feature:
Macro AXIS_DOWNSIZER_PREFETCH_EN.
- Defined: the prefetch term is (last && axis_mif.tready). A new wide word loads in the same cycle the final beat handshakes, giving 100% output throughput (one beat per cycle under continuous valid/ready). This adds a combinational path from axis_mif.tready to axis_sif.tready.
- Undefined: the prefetch term is 0. axis_sif.tready is purely registered-state based (no ready path through the block). There is one idle output cycle between consecutive words, so throughput is RATIO/(RATIO+1).

Test Plan:
- Reset release, RATIO=4, IN_W=32, OUT_W=8, sif word 0x44332211 with mif.tready=1 -> mif beats 0x11, 0x22, 0x33, 0x44 on 4 consecutive cycles, starting 1 cycle after s_hs; tvalid=0 and sif.tready=0 during rst.
- Back-to-back words 0xDDCCBBAA then 0x04030201, mif.tready=1 -> 8 beats AA,BB,CC,DD,01,02,03,04; with PREFETCH_EN no gap; without it exactly 1 tvalid=0 cycle between DD and 01.
- Backpressure: mif.tready low for 3 cycles at idx=2 of 0x44332211 -> tdata held at 0x33 with tvalid=1; then 0x33, 0x44 are emitted, with no loss or duplication.
- invalidate asserted after beat 0x22 handshakes -> next cycle tvalid=0, idx=0; sif.tready=0 during the invalidate cycle; the following word 0x88776655 emits 0x55 first.
- Reset mid-word at idx=1 -> tvalid=0 the next cycle; after release the next word starts at slice 0.
- RATIO=1, IN_W=OUT_W=16, random valid/ready over 1000 cycles -> output sequence equals input sequence, with at most 1 word held.
